// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: transmit framer states, GMII beat type and
// CRC-32 constants used by both the TX framer and the RX checker.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    SFD,
    DATA,
    DROP,
    PAD,
    FCS,
    IFG
  } tx_state_e;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } gmii_tx_t;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/eth_crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected 802.3 polynomial, data LSB first).
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [7:0]  data,
  input  logic [31:0] crc_in,
  output logic [31:0] crc_out
);

  always_comb begin
    crc_out = crc_in;
    for (int i = 0; i < 8; i++) begin
      crc_out = {1'b0, crc_out[31:1]} ^ ((crc_out[0] ^ data[i]) ? CRC32_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/eth_gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD insertion, zero padding, FCS append and
// inter-frame gap, one byte per gmii_tx_clk.
module eth_gmii_tx_framer
  import eth_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_PAYLOAD  = 60,
  parameter int IFG_CYCLES   = 12,
  parameter int CNT_W        = 11
) (
  input  logic       gmii_tx_clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_error,
  output logic       s_ready,
  output logic [7:0] gmii_txd,
  output logic       gmii_tx_en,
  output logic       gmii_tx_er,
  output logic       frame_done,
  output logic       frame_abort
);

  localparam int PH_W = 8;
  localparam logic [PH_W-1:0]  PRE_LAST = PH_W'(PREAMBLE_LEN - 1);
  localparam logic [PH_W-1:0]  IFG_LAST = PH_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W:0]   MIN_P    = (CNT_W + 1)'(MIN_PAYLOAD);

  tx_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic [CNT_W:0]   cnt_p1;
  logic [PH_W-1:0]  ph, ph_nx;
  logic [31:0]      crc, crc_nx, crc_step, fcs;
  logic [7:0]       crc_din, fcs_byte;
  gmii_tx_t         tx, tx_nx;
  logic             done_nx, abort_nx;
  logic             accept;

  assign s_ready = (state == DATA) || (state == DROP);
  assign accept  = s_valid && s_ready;

  // Pad bytes feed zeros into the CRC; otherwise the accepted payload byte.
  assign crc_din = (state == PAD) ? 8'h00 : s_data;

  eth_crc32_d8 u_crc (
    .data    (crc_din),
    .crc_in  (crc),
    .crc_out (crc_step)
  );

  assign cnt_p1  = {1'b0, cnt} + 1'b1;
  assign cnt_inc = (&cnt) ? cnt : cnt + 1'b1;
  assign fcs     = ~crc;

  always_comb begin
    unique case (ph[1:0])
      2'd0:    fcs_byte = fcs[7:0];
      2'd1:    fcs_byte = fcs[15:8];
      2'd2:    fcs_byte = fcs[23:16];
      default: fcs_byte = fcs[31:24];
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    ph_nx    = ph;
    crc_nx   = crc;
    tx_nx    = '0;
    done_nx  = 1'b0;
    abort_nx = 1'b0;
    unique case (state)
      IDLE: begin
        if (s_valid) begin
          state_nx = PRE;
          ph_nx    = '0;
        end
      end
      PRE: begin
        tx_nx.txd = ETH_PREAMBLE;
        tx_nx.en  = 1'b1;
        if (ph == PRE_LAST) begin
          state_nx = SFD;
          ph_nx    = '0;
        end else begin
          ph_nx = ph + 1'b1;
        end
      end
      SFD: begin
        tx_nx.txd = ETH_SFD;
        tx_nx.en  = 1'b1;
        crc_nx    = CRC32_INIT;
        cnt_nx    = '0;
        state_nx  = DATA;
      end
      DATA: begin
        // Underrun and flagged errors both poison the frame with one tx_er beat.
        if (!s_valid || s_error) begin
          tx_nx.en = 1'b1;
          tx_nx.er = 1'b1;
          abort_nx = 1'b1;
          state_nx = (s_valid && s_last) ? IFG : DROP;
          ph_nx    = '0;
        end else begin
          tx_nx.txd = s_data;
          tx_nx.en  = 1'b1;
          crc_nx    = crc_step;
          cnt_nx    = cnt_inc;
          if (s_last) begin
            state_nx = (cnt_p1 < MIN_P) ? PAD : FCS;
            ph_nx    = '0;
          end
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_nx = IFG;
          ph_nx    = '0;
        end
      end
      PAD: begin
        tx_nx.en = 1'b1;
        crc_nx   = crc_step;
        cnt_nx   = cnt_inc;
        if (cnt_p1 >= MIN_P) begin
          state_nx = FCS;
          ph_nx    = '0;
        end
      end
      FCS: begin
        tx_nx.txd = fcs_byte;
        tx_nx.en  = 1'b1;
        if (ph[1:0] == 2'd3) begin
          done_nx  = 1'b1;
          state_nx = IFG;
          ph_nx    = '0;
        end else begin
          ph_nx = ph + 1'b1;
        end
      end
      IFG: begin
        if (ph == IFG_LAST) begin
          state_nx = IDLE;
          ph_nx    = '0;
        end else begin
          ph_nx = ph + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge gmii_tx_clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ph          <= '0;
      crc         <= CRC32_INIT;
      tx          <= '0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ph          <= ph_nx;
      crc         <= crc_nx;
      tx          <= tx_nx;
      frame_done  <= done_nx;
      frame_abort <= abort_nx;
    end
  end

  assign gmii_txd   = tx.txd;
  assign gmii_tx_en = tx.en;
  assign gmii_tx_er = tx.er;

endmodule

// File: tb/tb_eth_gmii_tx_framer.sv
// Scoreboard bench for eth_gmii_tx_framer: expected GMII beats are queued as
// frames are driven and popped by a negedge monitor.
module tb_eth_gmii_tx_framer;

  logic       gmii_tx_clk = 1'b0;
  logic       reset       = 1'b1;
  logic [7:0] s_data      = 8'h00;
  logic       s_valid     = 1'b0;
  logic       s_last      = 1'b0;
  logic       s_error     = 1'b0;
  logic       s_ready;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, frame_done, frame_abort;

  eth_gmii_tx_framer dut (
    .gmii_tx_clk (gmii_tx_clk),
    .reset       (reset),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_error     (s_error),
    .s_ready     (s_ready),
    .gmii_txd    (gmii_txd),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_tx_er  (gmii_tx_er),
    .frame_done  (frame_done),
    .frame_abort (frame_abort)
  );

  always #4 gmii_tx_clk = ~gmii_tx_clk;

  int          n_cmp = 0, n_bad = 0;
  logic [8:0]  exp_q[$];
  int          run_q[$], gap_q[$];
  logic [31:0] res_q[$];
  int          hi_run = 0, lo_run = 0, n_done = 0, n_abort = 0, ifg_left = 0, ifg_bad = 0;
  logic        en_d = 1'b0, run_er = 1'b0;
  logic [31:0] run_crc = 32'hFFFFFFFF;
  logic [7:0]  pl[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction

  // Monitor: beat scoreboard, run/gap lengths, residue, pulse counts, IFG s_ready.
  always @(negedge gmii_tx_clk) begin
    logic [8:0] e;
    if (frame_done)  n_done++;
    if (frame_abort) n_abort++;
    if (frame_done)  ifg_left = 12;
    if (ifg_left > 0) begin
      if (s_ready) ifg_bad++;
      ifg_left--;
    end
    if (gmii_tx_en) begin
      if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        chk("beat", {gmii_tx_er, gmii_txd}, e);
      end
      if (!en_d) begin
        gap_q.push_back(lo_run);
        hi_run  = 0;
        run_crc = 32'hFFFFFFFF;
        run_er  = 1'b0;
      end
      hi_run++;
      if (hi_run > 8) run_crc = crc8(run_crc, gmii_txd);
      if (gmii_tx_er) run_er = 1'b1;
    end else begin
      if (en_d) begin
        run_q.push_back(hi_run);
        if (!run_er) res_q.push_back(run_crc);
        lo_run = 0;
      end
      lo_run++;
    end
    en_d = gmii_tx_en;
  end

  task automatic put_byte(input logic [7:0] d, input logic l, input logic e);
    int   n = 0;
    logic acc;
    s_data = d; s_valid = 1'b1; s_last = l; s_error = e;
    do begin
      @(negedge gmii_tx_clk);
      acc = s_ready;
      @(posedge gmii_tx_clk); #1;
      n++;
    end while (!acc && n < 400);
    if (!acc) chk("accept_timeout", n, 0);
  endtask

  task automatic send_frame(input logic [7:0] p[$], input int err_at, input int stall_after,
                            input int stall_len);
    logic [7:0]  fr[$];
    logic [31:0] c;
    int          n = p.size();
    for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    if (err_at >= 0) begin
      for (int i = 0; i < err_at; i++) exp_q.push_back({1'b0, p[i]});
      exp_q.push_back(9'h100);
    end else if (stall_after >= 0) begin
      for (int i = 0; i <= stall_after; i++) exp_q.push_back({1'b0, p[i]});
      exp_q.push_back(9'h100);
    end else begin
      fr = p;
      while (fr.size() < 60) fr.push_back(8'h00);
      c = 32'hFFFFFFFF;
      foreach (fr[i]) begin
        c = crc8(c, fr[i]);
        exp_q.push_back({1'b0, fr[i]});
      end
      c = ~c;
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, c[8*k +: 8]});
    end
    for (int i = 0; i < n; i++) begin
      if (stall_after >= 0 && i == stall_after + 1) begin
        s_valid = 1'b0;
        repeat (stall_len) @(posedge gmii_tx_clk);
        #1;
      end
      put_byte(p[i], i == n - 1, i == err_at);
    end
    s_valid = 1'b0; s_last = 1'b0; s_error = 1'b0;
  endtask

  task automatic mk(input int n, input int base);
    pl.delete();
    for (int i = 0; i < n; i++) pl.push_back(8'((base + i) & 255));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(exp_q.size() == 0 && !gmii_tx_en && lo_run >= 20) && n < 3000) begin
      @(posedge gmii_tx_clk);
      n++;
    end
    if (n >= 3000) chk("idle_timeout", n, 0);
    #1;
  endtask

  task automatic clr();
    run_q.delete(); gap_q.delete(); res_q.delete(); ifg_bad = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_done, d_abort, n;
    repeat (3) @(posedge gmii_tx_clk);
    @(negedge gmii_tx_clk);
    chk("rst_txd",   gmii_txd,    0);
    chk("rst_en",    gmii_tx_en,  0);
    chk("rst_er",    gmii_tx_er,  0);
    chk("rst_ready", s_ready,     0);
    chk("rst_done",  frame_done,  0);
    chk("rst_abort", frame_abort, 0);
    @(posedge gmii_tx_clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge gmii_tx_clk); #1;

    // 1: minimum-size frame, no padding
    clr(); d_done = n_done;
    mk(60, 0);
    send_frame(pl, -1, -1, 0);
    wait_idle();
    chk("t1_run",     run_q.size() > 0 ? run_q[0] : -1, 72);
    chk("t1_residue", res_q.size() > 0 ? res_q[0] : 0, 32'hDEBB20E3);
    chk("t1_done",    n_done - d_done, 1);

    // 2: single byte, padded to 60
    clr(); d_done = n_done;
    pl.delete(); pl.push_back(8'hAB);
    send_frame(pl, -1, -1, 0);
    wait_idle();
    chk("t2_run",     run_q.size() > 0 ? run_q[0] : -1, 72);
    chk("t2_residue", res_q.size() > 0 ? res_q[0] : 0, 32'hDEBB20E3);
    chk("t2_done",    n_done - d_done, 1);

    // 3: two 64-byte frames back to back
    clr(); d_done = n_done;
    mk(64, 8'h40);
    send_frame(pl, -1, -1, 0);
    mk(64, 8'h90);
    send_frame(pl, -1, -1, 0);
    wait_idle();
    chk("t3_run0",      run_q.size() > 0 ? run_q[0] : -1, 76);
    chk("t3_run1",      run_q.size() > 1 ? run_q[1] : -1, 76);
    chk("t3_gap",       gap_q.size() > 1 ? gap_q[1] : -1, 13);
    chk("t3_ifg_ready", ifg_bad, 0);
    chk("t3_residue1",  res_q.size() > 1 ? res_q[1] : 0, 32'hDEBB20E3);
    chk("t3_done",      n_done - d_done, 2);

    // 4: underrun after byte index 10 of 100, then a normal frame right behind it
    clr(); d_done = n_done; d_abort = n_abort;
    mk(100, 8'h10);
    send_frame(pl, -1, 10, 3);
    mk(60, 8'hC0);
    send_frame(pl, -1, -1, 0);
    wait_idle();
    chk("t4_run",   run_q.size() > 0 ? run_q[0] : -1, 20);
    chk("t4_gap",   gap_q.size() > 1 ? gap_q[1] : -1, 104);
    chk("t4_abort", n_abort - d_abort, 1);
    chk("t4_done",  n_done - d_done, 1);

    // 5: s_error on byte 20 of 80
    clr(); d_done = n_done; d_abort = n_abort;
    mk(80, 8'h22);
    send_frame(pl, 20, -1, 0);
    wait_idle();
    chk("t5_run",   run_q.size() > 0 ? run_q[0] : -1, 29);
    chk("t5_abort", n_abort - d_abort, 1);
    chk("t5_done",  n_done - d_done, 0);

    // 6: reset pulse during FCS, then a clean frame
    clr(); d_done = n_done;
    mk(60, 8'h77);
    send_frame(pl, -1, -1, 0);
    n = 0;
    while (hi_run != 69 && n < 200) begin
      @(posedge gmii_tx_clk);
      n++;
    end
    if (n >= 200) chk("t6_fcs_timeout", n, 0);
    #1; reset = 1'b1;
    @(posedge gmii_tx_clk); #1;
    reset = 1'b0;
    chk("t6_left", exp_q.size(), 2);
    exp_q.delete();
    @(negedge gmii_tx_clk);
    chk("t6_en",   gmii_tx_en, 0);
    chk("t6_er",   gmii_tx_er, 0);
    chk("t6_txd",  gmii_txd,   0);
    chk("t6_done", n_done - d_done, 0);
    repeat (5) @(posedge gmii_tx_clk); #1;
    clr(); d_done = n_done;
    mk(70, 8'h05);
    send_frame(pl, -1, -1, 0);
    wait_idle();
    chk("t6_run",     run_q.size() > 0 ? run_q[0] : -1, 82);
    chk("t6_residue", res_q.size() > 0 ? res_q[0] : 0, 32'hDEBB20E3);
    chk("t6_done2",   n_done - d_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
